// File: rtl/my_noc_fabric_if.sv
// Source/destination bundle of the multiplier-to-adder fabric: packed source
// words in, packed accumulators and per-source stall out.
interface my_noc_fabric_if #(
  parameter int bit_width = 2,
  parameter int log_n_mul = 4,
  parameter int log_n_add = 3,
  parameter int ctrl_bit  = 1
);
  localparam int N_MUL = 1 << log_n_mul;
  localparam int N_ADD = 1 << log_n_add;
  localparam int W     = ctrl_bit + log_n_add + bit_width;

  logic [N_MUL*W-1:0]         in;
  logic [N_ADD*bit_width-1:0] out;
  logic [N_MUL-1:0]           stall;

  modport master (output in, input out, input stall);
  modport slave  (input in, output out, output stall);
endinterface

// File: rtl/my_noc_fabric.sv
// Many-to-few fabric: one-entry buffer per source, round-robin arbitration per
// destination, and a wrap-around accumulator per destination adder.
module my_noc_fabric #(
  parameter int bit_width = 2,
  parameter int log_n_mul = 4,
  parameter int log_n_add = 3,
  parameter int ctrl_bit  = 1
) (
  input logic            clk,
  input logic            rst,
  my_noc_fabric_if.slave bus
);
  localparam int N_MUL = 1 << log_n_mul;
  localparam int N_ADD = 1 << log_n_add;
  localparam int W     = ctrl_bit + log_n_add + bit_width;

  logic [N_MUL-1:0]     bvalid;
  logic [log_n_add-1:0] baddr [N_MUL];
  logic [bit_width-1:0] bdata [N_MUL];
  logic [log_n_mul-1:0] rr    [N_ADD];
  logic [bit_width-1:0] acc   [N_ADD];

  logic [N_MUL-1:0]     grant;
  logic [N_ADD-1:0]     hit;
  logic [log_n_mul-1:0] win   [N_ADD];

  // Scan starts at rr[d]; the index adder wraps naturally at N_MUL.
  always_comb begin
    logic                 found;
    logic [log_n_mul-1:0] idx;
    logic [log_n_mul-1:0] w;
    grant = '0;
    hit   = '0;
    found = 1'b0;
    idx   = '0;
    w     = '0;
    for (int unsigned d = 0; d < N_ADD; d++) begin
      found = 1'b0;
      w     = '0;
      for (int unsigned k = 0; k < N_MUL; k++) begin
        idx = rr[d] + log_n_mul'(k);
        if (!found && bvalid[idx] && (baddr[idx] == log_n_add'(d))) begin
          found = 1'b1;
          w     = idx;
        end
      end
      hit[d] = found;
      win[d] = w;
      if (found) grant[w] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid <= '0;
      for (int unsigned i = 0; i < N_MUL; i++) begin
        baddr[i] <= '0;
        bdata[i] <= '0;
      end
      for (int unsigned d = 0; d < N_ADD; d++) begin
        rr[d]  <= '0;
        acc[d] <= '0;
      end
    end else begin
      // An occupied buffer ignores its input even when it drains this edge.
      for (int unsigned i = 0; i < N_MUL; i++) begin
        if (!bvalid[i]) begin
          if (bus.in[i*W + W - 1]) begin
            bvalid[i] <= 1'b1;
            baddr[i]  <= bus.in[i*W + bit_width +: log_n_add];
            bdata[i]  <= bus.in[i*W +: bit_width];
          end
        end else if (grant[i]) begin
          bvalid[i] <= 1'b0;
        end
      end
      for (int unsigned d = 0; d < N_ADD; d++) begin
        if (hit[d]) begin
          acc[d] <= acc[d] + bdata[win[d]];
          rr[d]  <= win[d] + 1'b1;
        end
      end
    end
  end

  assign bus.stall = bvalid;

  always_comb begin
    bus.out = '0;
    for (int unsigned d = 0; d < N_ADD; d++) bus.out[d*bit_width +: bit_width] = acc[d];
  end
endmodule

// File: tb/tb_my_noc_fabric.sv
// Bench for my_noc_fabric: directed vector table, then random traffic against
// a cycle-level reference model of buffers, round-robin pointers and adders.
module tb_my_noc_fabric;
  localparam int BW = 2, LM = 4, LA = 3, CB = 1;
  localparam int NM = 16, NA = 8, W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  my_noc_fabric_if #(.bit_width(BW), .log_n_mul(LM), .log_n_add(LA), .ctrl_bit(CB)) bus ();

  my_noc_fabric #(.bit_width(BW), .log_n_mul(LM), .log_n_add(LA), .ctrl_bit(CB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic              r;
    logic [NM*W-1:0]   iv;
    logic [NA*BW-1:0]  eo;
    logic [NM-1:0]     es;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int mv[NM], ma[NM], md[NM];
  int mrr[NA], macc[NA];

  function automatic logic [W-1:0] wd(input int v, input int a, input int d);
    logic [W-1:0] x;
    x = {v[0], a[2:0], d[1:0]};
    return x;
  endfunction

  function automatic void add(input logic r, input logic [NM*W-1:0] iv,
                              input logic [NA*BW-1:0] eo, input logic [NM-1:0] es);
    vec_t v;
    v.r = r; v.iv = iv; v.eo = eo; v.es = es;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NM; s++) begin mv[s] = 0; ma[s] = 0; md[s] = 0; end
    for (int d = 0; d < NA; d++) begin mrr[d] = 0; macc[d] = 0; end
  endtask

  task automatic model_step(input logic r, input logic [NM*W-1:0] iv);
    int wn[NA];
    logic [W-1:0] x;
    if (r) begin
      model_reset();
      return;
    end
    for (int d = 0; d < NA; d++) begin
      wn[d] = -1;
      for (int k = 0; k < NM; k++) begin
        int s;
        s = (mrr[d] + k) % NM;
        if (wn[d] < 0 && mv[s] == 1 && ma[s] == d) wn[d] = s;
      end
    end
    for (int d = 0; d < NA; d++)
      if (wn[d] >= 0) begin
        macc[d] = (macc[d] + md[wn[d]]) % 4;
        mrr[d]  = (wn[d] + 1) % NM;
        mv[wn[d]] = 2;  // drained this edge: cannot capture
      end
    for (int s = 0; s < NM; s++) begin
      x = iv[s*W +: W];
      if (mv[s] == 2) mv[s] = 0;
      else if (mv[s] == 0 && x[5]) begin
        mv[s] = 1; ma[s] = int'(x[4:2]); md[s] = int'(x[1:0]);
      end
    end
  endtask

  function automatic logic [NA*BW-1:0] model_out();
    logic [NA*BW-1:0] o;
    o = '0;
    for (int d = 0; d < NA; d++) o[d*BW +: BW] = 2'(macc[d]);
    return o;
  endfunction

  function automatic logic [NM-1:0] model_stall();
    logic [NM-1:0] s;
    s = '0;
    for (int i = 0; i < NM; i++) s[i] = (mv[i] == 1);
    return s;
  endfunction

  initial begin
    logic [NM*W-1:0] iv;
    logic [NM-1:0]   es;

    // reset with arbitrary input
    iv = '1;
    add(1, iv, '0, '0);
    add(1, iv, '0, '0);
    // single word: source 0, ADD=2, DATA=3
    iv = '0; iv[0 +: W] = 6'h2B;
    add(0, iv, '0, 16'h0001);
    iv = '0;
    add(0, iv, 16'h0030, '0);
    add(0, iv, 16'h0030, '0);
    // contention from a fresh pointer: source 0 first, then 1; 3+1 wraps to 0
    add(1, iv, '0, '0);
    iv[0 +: W] = 6'h2B; iv[W +: W] = 6'h29;
    add(0, iv, '0, 16'h0003);
    iv = '0;
    add(0, iv, 16'h0030, 16'h0002);
    add(0, iv, 16'h0000, '0);
    // repeat the pair: pointer is now 2, so the wrapping scan reaches 0 before 1
    iv[0 +: W] = 6'h2B; iv[W +: W] = 6'h29;
    add(0, iv, '0, 16'h0003);
    iv = '0;
    add(0, iv, 16'h0030, 16'h0002);
    add(0, iv, 16'h0000, '0);
    // parallel destinations
    add(1, iv, '0, '0);
    for (int i = 0; i < 8; i++) iv[i*W +: W] = wd(1, i, 1);
    add(0, iv, '0, 16'h00FF);
    iv = '0;
    add(0, iv, 16'h5555, '0);
    // full contention on destination 7
    add(1, iv, '0, '0);
    for (int i = 0; i < NM; i++) iv[i*W +: W] = wd(1, 7, 1);
    add(0, iv, '0, 16'hFFFF);
    iv = '0;
    for (int j = 1; j <= NM; j++) begin
      logic [NA*BW-1:0] o;
      es = 16'hFFFF; es = es << j;
      o = '0; o[15:14] = 2'(j % 4);
      add(0, iv, o, es);
    end
    // source 3 held valid to destination 0: capture every other edge
    add(1, iv, '0, '0);
    iv[3*W +: W] = wd(1, 0, 1);
    for (int e = 1; e <= 8; e++) begin
      logic [NA*BW-1:0] o;
      o = '0; o[1:0] = 2'(e / 2);
      add(0, iv, o, (e % 2 == 1) ? 16'h0008 : 16'h0000);
    end
    iv = '0; iv[3*W +: W] = wd(0, 5, 3);
    add(0, iv, '0, '0);
    iv[3*W +: W] = wd(1, 0, 1);
    add(0, iv, '0, 16'h0008);
    add(0, iv, 16'h0001, '0);
    add(0, iv, 16'h0001, 16'h0008);
    add(1, iv, '0, '0);

    // directed vectors
    for (int t = 0; t < tbl.size(); t++) begin
      rst    = tbl[t].r;
      bus.in = tbl[t].iv;
      @(posedge clk); #1;
      check($sformatf("vec%0d_out", t),   32'(bus.out),   32'(tbl[t].eo));
      check($sformatf("vec%0d_stall", t), 32'(bus.stall), 32'(tbl[t].es));
    end

    // random traffic against the model
    rst = 1'b1; bus.in = '0;
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [NM*W-1:0] r_in;
      int mode;
      mode = $urandom_range(0, 2);
      r_in = '0;
      for (int i = 0; i < NM; i++) begin
        int a;
        a = (mode == 0) ? $urandom_range(0, 1) : $urandom_range(0, 7);
        r_in[i*W +: W] = wd(($urandom_range(0, 3) != 0) ? 1 : 0, a, $urandom_range(0, 3));
      end
      rst    = ($urandom_range(0, 59) == 0);
      bus.in = r_in;
      model_step(rst, r_in);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_out", c),   32'(bus.out),   32'(model_out()));
      check($sformatf("rnd%0d_stall", c), 32'(bus.stall), 32'(model_stall()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
